// File: rtl/t10_guess_checker.sv
// -----------------------------------------------------------------------------
// t10_guess_checker
//
// Game-logic stage that sits behind the host message register. When the host
// word is complete (rec_ready high) the 40-bit secret is latched and a masked
// copy is shown to the player. Letter guesses reveal matching bytes or count
// as mistakes. The block ends in WIN or LOSE and pulses game_end so the host
// register can clear itself.
//
// Optional feature macro: T10_REPEAT_GUARD_EN
//   defined   : a 26-bit guessed-letter mask rejects repeated letters, which
//               then pulse repeat_guess only.
//   undefined : no mask; repeat_guess is tied low, and repeats are evaluated
//               like fresh guesses.
//
// Parameters
//   MAX_MISTAKES  number of wrong guesses that cause LOSE (legal 1..7)
//
// Ports
//   clk           system clock
//   nRst          asynchronous active-low reset
//   rec_ready     host word complete (level)
//   temp_word     host secret, byte 4 = [39:32] ... byte 0 = [7:0]
//   guess_letter  player guess, ASCII
//   guess_valid   single-cycle guess strobe
//   restart       single-cycle new-game request
//   disp_word     masked word shown to the player (registered)
//   mistakes      wrong-guess count (registered)
//   letter_hit    one-cycle pulse: last guess matched at least one byte
//   letter_miss   one-cycle pulse: last guess counted as a mistake
//   repeat_guess  one-cycle pulse: guess rejected as a repeat
//   win           level, high while in WIN
//   lose          level, high while in LOSE
//   game_end      one-cycle pulse on entry to WIN or LOSE
//   state_dbg     current FSM state (IDLE=0, PLAY=1, WIN=2, LOSE=3)
//
// Handshake: guess_valid and restart are single-cycle strobes sampled on the
// rising clock edge with no back-pressure; rec_ready is a level qualifying the
// host word. Every output is registered and reflects inputs sampled at the
// previous rising edge.
// -----------------------------------------------------------------------------
module t10_guess_checker #(
  parameter int MAX_MISTAKES = 6
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rec_ready,
  input  logic [39:0] temp_word,
  input  logic [7:0]  guess_letter,
  input  logic        guess_valid,
  input  logic        restart,
  output logic [39:0] disp_word,
  output logic [2:0]  mistakes,
  output logic        letter_hit,
  output logic        letter_miss,
  output logic        repeat_guess,
  output logic        win,
  output logic        lose,
  output logic        game_end,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  localparam logic [7:0]  BLANK     = 8'h5F;
  localparam logic [39:0] ALL_BLANK = {5{BLANK}};
  localparam logic [2:0]  MAX_M     = 3'(MAX_MISTAKES);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  // Hide every letter byte; non-letter bytes (blanks, digits, ...) stay visible.
  function automatic logic [39:0] mask_word(input logic [39:0] w);
    logic [39:0] r;
    r = w;
    for (int i = 0; i < 5; i++) begin
      if (is_letter(w[i*8 +: 8])) r[i*8 +: 8] = BLANK;
    end
    return r;
  endfunction

  // Win test: every letter byte of the secret is already shown. Non-letter
  // bytes count as revealed, so an all-blank secret wins immediately.
  function automatic logic all_revealed(input logic [39:0] s,
                                        input logic [39:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (is_letter(s[i*8 +: 8]) && (d[i*8 +: 8] != s[i*8 +: 8])) ok = 1'b0;
    end
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state, state_n;
  logic [39:0] secret, secret_n;
  logic [39:0] disp_n;
  logic [2:0]  mistakes_n;
  logic        hit_n, miss_n, rep_n, end_n;

  // Guess decode shared by all branches
  logic        guess_ok;
  logic        any_match;
  logic [39:0] reveal_word;

  assign guess_ok = guess_valid && is_letter(guess_letter);

  always_comb begin
    any_match   = 1'b0;
    reveal_word = disp_word;
    for (int i = 0; i < 5; i++) begin
      if (secret[i*8 +: 8] == guess_letter) begin
        any_match            = 1'b1;
        reveal_word[i*8 +: 8] = guess_letter;
      end
    end
  end

`ifdef T10_REPEAT_GUARD_EN
  logic [25:0] guess_mask, guess_mask_n;
  logic [25:0] guess_onehot;
  logic        guess_seen;

  always_comb begin
    guess_onehot = '0;
    for (int i = 0; i < 26; i++) begin
      guess_onehot[i] = (guess_letter == 8'(8'h41 + i));
    end
  end

  assign guess_seen = |(guess_mask & guess_onehot);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    logic do_eval;
    state_n    = state;
    secret_n   = secret;
    disp_n     = disp_word;
    mistakes_n = mistakes;
    hit_n      = 1'b0;
    miss_n     = 1'b0;
    rep_n      = 1'b0;
    end_n      = 1'b0;
    do_eval    = 1'b0;
`ifdef T10_REPEAT_GUARD_EN
    guess_mask_n = guess_mask;
`endif

    if (restart) begin
      // restart beats everything else, in every state
      state_n    = ST_IDLE;
      disp_n     = ALL_BLANK;
      mistakes_n = 3'd0;
`ifdef T10_REPEAT_GUARD_EN
      guess_mask_n = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          disp_n     = ALL_BLANK;
          mistakes_n = 3'd0;
`ifdef T10_REPEAT_GUARD_EN
          guess_mask_n = '0;
`endif
          // A guess arriving on the latch edge is deliberately dropped.
          if (rec_ready) begin
            secret_n = temp_word;
            disp_n   = mask_word(temp_word);
            state_n  = ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (!rec_ready) begin
            // Host aborted the word: silent return, no game_end.
            state_n    = ST_IDLE;
            disp_n     = ALL_BLANK;
            mistakes_n = 3'd0;
`ifdef T10_REPEAT_GUARD_EN
            guess_mask_n = '0;
`endif
          end else begin
            if (guess_ok) begin
`ifdef T10_REPEAT_GUARD_EN
              if (guess_seen) begin
                rep_n = 1'b1;
              end else begin
                guess_mask_n = guess_mask | guess_onehot;
                do_eval      = 1'b1;
              end
`else
              do_eval = 1'b1;
`endif
            end

            if (do_eval) begin
              if (any_match) begin
                disp_n = reveal_word;
                hit_n  = 1'b1;
              end else begin
                mistakes_n = mistakes + 3'd1;
                miss_n     = 1'b1;
              end
            end

            // Judged on post-update values; WIN is checked first. Evaluated
            // every PLAY cycle so an all-blank secret wins without a guess.
            if (all_revealed(secret, disp_n)) begin
              state_n = ST_WIN;
              end_n   = 1'b1;
            end else if (mistakes_n == MAX_M) begin
              state_n = ST_LOSE;
              end_n   = 1'b1;
            end
          end
        end

        ST_WIN, ST_LOSE: begin
          // Terminal: hold everything until restart.
        end

        default: begin
          state_n    = ST_IDLE;
          disp_n     = ALL_BLANK;
          mistakes_n = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= ST_IDLE;
      secret      <= '0;
      disp_word   <= ALL_BLANK;
      mistakes    <= 3'd0;
      letter_hit  <= 1'b0;
      letter_miss <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      game_end    <= 1'b0;
    end else begin
      state       <= state_n;
      secret      <= secret_n;
      disp_word   <= disp_n;
      mistakes    <= mistakes_n;
      letter_hit  <= hit_n;
      letter_miss <= miss_n;
      win         <= (state_n == ST_WIN);
      lose        <= (state_n == ST_LOSE);
      game_end    <= end_n;
    end
  end

`ifdef T10_REPEAT_GUARD_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      guess_mask   <= '0;
      repeat_guess <= 1'b0;
    end else begin
      guess_mask   <= guess_mask_n;
      repeat_guess <= rep_n;
    end
  end
`else
  // rep_n is never raised without the mask; the output stays low.
  assign repeat_guess = rep_n & 1'b0;
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_t10_guess_checker.sv
// -----------------------------------------------------------------------------
// tb_t10_guess_checker
//
// Bench for t10_guess_checker: reset check, a table of directed vectors,
// hand-written sequences for repeats and mid-game reset, and a randomized run
// against a word-level game model.
// -----------------------------------------------------------------------------
module tb_t10_guess_checker;

  localparam int MAXM = 6;
`ifdef T10_REPEAT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [39:0] BLANKS = 40'h5F5F5F5F5F;
  localparam logic [39:0] APPLE  = 40'h4150504C45;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        nRst;
  logic        rec_ready;
  logic [39:0] temp_word;
  logic [7:0]  guess_letter;
  logic        guess_valid;
  logic        restart;
  logic [39:0] disp_word;
  logic [2:0]  mistakes;
  logic        letter_hit, letter_miss, repeat_guess, win, lose, game_end;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  t10_guess_checker #(.MAX_MISTAKES(MAXM)) dut (
    .clk(clk), .nRst(nRst), .rec_ready(rec_ready), .temp_word(temp_word),
    .guess_letter(guess_letter), .guess_valid(guess_valid), .restart(restart),
    .disp_word(disp_word), .mistakes(mistakes), .letter_hit(letter_hit),
    .letter_miss(letter_miss), .repeat_guess(repeat_guess), .win(win),
    .lose(lose), .game_end(game_end), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [39:0] e_disp,
                           input logic [2:0] e_mis, input logic e_hit,
                           input logic e_miss, input logic e_rep,
                           input logic e_win, input logic e_lose,
                           input logic e_end);
    check({tag, ".disp"},  disp_word,            e_disp);
    check({tag, ".mis"},   40'(mistakes),        40'(e_mis));
    check({tag, ".hit"},   40'(letter_hit),      40'(e_hit));
    check({tag, ".miss"},  40'(letter_miss),     40'(e_miss));
    check({tag, ".rep"},   40'(repeat_guess),    40'(e_rep));
    check({tag, ".win"},   40'(win),             40'(e_win));
    check({tag, ".lose"},  40'(lose),            40'(e_lose));
    check({tag, ".end"},   40'(game_end),        40'(e_end));
  endtask

  // drive at the falling edge, sample 1 ns after the rising edge
  task automatic drive(input logic rr, input logic [39:0] tw, input logic gv,
                       input logic [7:0] gl, input logic rs);
    @(negedge clk);
    rec_ready    = rr;
    temp_word    = tw;
    guess_valid  = gv;
    guess_letter = gl;
    restart      = rs;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rr;
    logic [39:0] tw;
    logic        gv;
    logic [7:0]  gl;
    logic        rs;
    logic [39:0] e_disp;
    logic [2:0]  e_mis;
    logic        e_hit, e_miss, e_win, e_lose, e_end;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rr, input logic [39:0] tw,
                              input logic gv, input logic [7:0] gl,
                              input logic rs, input logic [39:0] e_disp,
                              input logic [2:0] e_mis, input logic e_hit,
                              input logic e_miss, input logic e_win,
                              input logic e_lose, input logic e_end);
    vec_t v;
    v.rr = rr; v.tw = tw; v.gv = gv; v.gl = gl; v.rs = rs;
    v.e_disp = e_disp; v.e_mis = e_mis; v.e_hit = e_hit; v.e_miss = e_miss;
    v.e_win = e_win; v.e_lose = e_lose; v.e_end = e_end;
    return v;
  endfunction

  task automatic build_table();
    //              rr  tw              gv  gl     rs  disp            mis  h  m  w  l  e
    // APPLE game won
    vecs.push_back(mk(1, APPLE,          0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h50, 0, 40'h5F50505F5F, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          0, 8'h00, 0, 40'h5F50505F5F, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h41, 0, 40'h4150505F5F, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h4C, 0, 40'h4150504C5F, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h45, 0, APPLE,          0,   1, 0, 1, 0, 1));
    vecs.push_back(mk(0, APPLE,          0, 8'h00, 0, APPLE,          0,   0, 0, 1, 0, 0));
    vecs.push_back(mk(0, APPLE,          1, 8'h5A, 0, APPLE,          0,   0, 0, 1, 0, 0));
    vecs.push_back(mk(0, APPLE,          0, 8'h00, 1, BLANKS,         0,   0, 0, 0, 0, 0));
    // APPLE game lost after six misses
    vecs.push_back(mk(1, APPLE,          0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h5A, 0, BLANKS,         1,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h59, 0, BLANKS,         2,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h58, 0, BLANKS,         3,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h57, 0, BLANKS,         4,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h56, 0, BLANKS,         5,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h55, 0, BLANKS,         6,   0, 1, 0, 1, 1));
    vecs.push_back(mk(0, APPLE,          1, 8'h41, 0, BLANKS,         6,   0, 0, 0, 1, 0));
    vecs.push_back(mk(0, APPLE,          0, 8'h00, 1, BLANKS,         0,   0, 0, 0, 0, 0));
    // "AB___" with non-letter guesses ignored
    vecs.push_back(mk(1, 40'h41425F5F5F, 0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41425F5F5F, 1, 8'h61, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41425F5F5F, 1, 8'h31, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41425F5F5F, 1, 8'h41, 0, 40'h415F5F5F5F, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41425F5F5F, 1, 8'h42, 0, 40'h41425F5F5F, 0,   1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 40'h0,          0, 8'h00, 1, BLANKS,         0,   0, 0, 0, 0, 0));
    // all-blank secret: PLAY then WIN on the next edge
    vecs.push_back(mk(1, BLANKS,         0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, BLANKS,         0, 8'h00, 0, BLANKS,         0,   0, 0, 1, 0, 1));
    vecs.push_back(mk(0, BLANKS,         0, 8'h00, 1, BLANKS,         0,   0, 0, 0, 0, 0));
    // guess on latch edge ignored; guess+restart -> IDLE; rec_ready drop
    vecs.push_back(mk(1, APPLE,          1, 8'h50, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h50, 1, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, APPLE,          1, 8'h51, 0, BLANKS,         1,   0, 1, 0, 0, 0));
    vecs.push_back(mk(0, APPLE,          0, 8'h00, 0, BLANKS,         0,   0, 0, 0, 0, 0));
    // mixed secret "A1_B." keeps digits and punctuation visible
    vecs.push_back(mk(1, 40'h41315F422E, 0, 8'h00, 0, 40'h5F315F5F2E, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41315F422E, 1, 8'h42, 0, 40'h5F315F422E, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40'h41315F422E, 1, 8'h41, 0, 40'h41315F422E, 0,   1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 40'h0,          0, 8'h00, 1, BLANKS,         0,   0, 0, 0, 0, 0));
  endtask

  // ---------------- game-level reference model ----------------
  string        m_phase;
  logic [7:0]   m_secret[5];
  logic [7:0]   m_shown[5];
  int           m_miss;
  bit           m_used[26];
  bit           m_hit, m_missp, m_rep, m_end;

  function automatic bit letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  task automatic model_idle();
    m_phase = "IDLE";
    m_miss  = 0;
    foreach (m_shown[i]) m_shown[i] = 8'h5F;
    foreach (m_used[i])  m_used[i]  = 1'b0;
  endtask

  task automatic model_reset();
    model_idle();
    foreach (m_secret[i]) m_secret[i] = 8'h00;
    m_hit = 0; m_missp = 0; m_rep = 0; m_end = 0;
  endtask

  task automatic model_step(input logic rr, input logic [39:0] tw,
                            input logic gv, input logic [7:0] gl,
                            input logic rs);
    int  n;
    bit  solved;
    m_hit = 0; m_missp = 0; m_rep = 0; m_end = 0;
    if (rs) begin
      model_idle();
    end else if (m_phase == "IDLE") begin
      if (rr) begin
        for (int i = 0; i < 5; i++) begin
          m_secret[i] = tw[i*8 +: 8];
          m_shown[i]  = letter(m_secret[i]) ? 8'h5F : m_secret[i];
        end
        m_phase = "PLAY";
      end
    end else if (m_phase == "PLAY") begin
      if (!rr) begin
        model_idle();
      end else begin
        if (gv && letter(gl)) begin
          if (GUARD && m_used[int'(gl) - 65]) begin
            m_rep = 1;
          end else begin
            m_used[int'(gl) - 65] = 1'b1;
            n = 0;
            for (int i = 0; i < 5; i++) begin
              if (m_secret[i] == gl) begin
                m_shown[i] = gl;
                n++;
              end
            end
            if (n > 0) m_hit = 1;
            else begin
              m_missp = 1;
              m_miss++;
            end
          end
        end
        solved = 1;
        for (int i = 0; i < 5; i++) begin
          if (m_shown[i] != m_secret[i]) solved = 0;
        end
        if (solved) begin
          m_phase = "WIN";
          m_end   = 1;
        end else if (m_miss == MAXM) begin
          m_phase = "LOSE";
          m_end   = 1;
        end
      end
    end
  endtask

  function automatic logic [39:0] model_word();
    logic [39:0] w;
    for (int i = 0; i < 5; i++) w[i*8 +: 8] = m_shown[i];
    return w;
  endfunction

  function automatic logic [7:0] rand_secret_byte();
    int k;
    k = $urandom_range(0, 9);
    if (k < 3)  return 8'h5F;
    if (k == 3) return 8'(8'h30 + $urandom_range(0, 9));
    return 8'(8'h41 + $urandom_range(0, 5));
  endfunction

  function automatic logic [7:0] rand_guess();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 8'(8'h61 + $urandom_range(0, 25));
    if (k == 1) return 8'($urandom_range(0, 255));
    return 8'(8'h41 + $urandom_range(0, 9));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [39:0] tw;
    logic        rr, gv, rs;
    logic [7:0]  gl;

    nRst = 1'b0; rec_ready = 1'b0; temp_word = '0; guess_letter = '0;
    guess_valid = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all("reset", BLANKS, 3'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;

    // directed table
    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].rr, vecs[i].tw, vecs[i].gv, vecs[i].gl, vecs[i].rs);
      check_all($sformatf("vec%0d", i), vecs[i].e_disp, vecs[i].e_mis,
                vecs[i].e_hit, vecs[i].e_miss, 1'b0, vecs[i].e_win,
                vecs[i].e_lose, vecs[i].e_end);
    end

    // repeated wrong letter
    drive(1, APPLE, 0, 8'h00, 0);
    drive(1, APPLE, 1, 8'h5A, 0);
    check_all("rep_first", BLANKS, 3'd1, 0, 1, 0, 0, 0, 0);
    drive(1, APPLE, 1, 8'h5A, 0);
    if (GUARD) check_all("rep_second", BLANKS, 3'd1, 0, 0, 1, 0, 0, 0);
    else       check_all("rep_second", BLANKS, 3'd2, 0, 1, 0, 0, 0, 0);
    // repeated right letter
    drive(1, APPLE, 1, 8'h50, 0);
    check("rep_hit1.disp", disp_word, 40'h5F50505F5F);
    drive(1, APPLE, 1, 8'h50, 0);
    check("rep_hit2.hit", 40'(letter_hit), GUARD ? 40'd0 : 40'd1);
    check("rep_hit2.rep", 40'(repeat_guess), GUARD ? 40'd1 : 40'd0);

    // asynchronous reset mid-game
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check_all("async_rst", BLANKS, 3'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;
    drive(0, '0, 0, 8'h00, 0);
    check("post_rst.disp", disp_word, BLANKS);

    // randomized run against the game model
    @(negedge clk);
    nRst = 1'b0; rec_ready = 1'b0; guess_valid = 1'b0; restart = 1'b0;
    model_reset();
    @(negedge clk);
    nRst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) tw[b*8 +: 8] = rand_secret_byte();
      rr = ($urandom_range(0, 24) != 0);
      gv = ($urandom_range(0, 9) < 6);
      gl = rand_guess();
      rs = ($urandom_range(0, 39) == 0);
      model_step(rr, tw, gv, gl, rs);
      drive(rr, tw, gv, gl, rs);
      check_all("rand", model_word(), 3'(m_miss), m_hit, m_missp, m_rep,
                m_phase == "WIN", m_phase == "LOSE", m_end);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
